frame_scanout: RTL and testbench
================================

Name: frame_scanout

Overview:
- Reader end of the pixel-plot interface that the game display engine drives (x, y, colour, plot).
- Captures plotted pixels into an internal 160x120x3 frame store.
- Independently scans the store in raster order, producing the colour stream, active-video flag and active-low syncs for the video DAC stage.
- Also provides a background-clear sweep used on game restart.

Parameters:
- H_ACTIVE, 160, visible columns.
- V_ACTIVE, 120, visible rows.
- H_TOTAL, 200, pixel ticks per line including blanking.
- V_TOTAL, 130, lines per frame including blanking.
- H_SYNC_START, 168, first column of hsync low; H_SYNC_LEN, 16.
- V_SYNC_START, 122, first line of vsync low; V_SYNC_LEN, 2.
- CLK_DIV, 2, clk cycles per pixel tick (>=1).
- BG_COLOUR, 3'b011, colour written by a clear sweep.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- x  in  8  write column.
- y  in  7  write row.
- colour  in  3  write colour.
- plot  in  1  write strobe; one pixel per clk while high.
- clear  in  1  pulse; starts the background sweep.
- clear_busy  out  1  high while the sweep runs.
- out_colour  out  3  scanned pixel colour; 0 outside active video.
- out_active  out  1  pixel inside the 160x120 window.
- out_hsync  out  1  active-low horizontal sync.
- out_vsync  out  1  active-low vertical sync.
- frame_start  out  1  one-clk pulse when raster enters (0,0).

Behaviour:
- Reset (async, resetn=0) values:
  - Divider, hcount and vcount = 0.
  - out_colour=0, out_active=0, out_hsync=1, out_vsync=1.
  - frame_start=0, clear_busy=0.
  - State IDLE.
  - Frame store contents are not reset.
- Pixel tick: pulses every CLK_DIV clks from the divider.
  - On each tick hcount increments and wraps at H_TOTAL-1 -> 0.
  - When hcount wraps, vcount increments and wraps at V_TOTAL-1 -> 0.
- Write port (state IDLE):
  - plot=1 with x<H_ACTIVE and y<V_ACTIVE writes colour at addr = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits.
  - Out-of-range coordinates are dropped silently.
  - Writes are independent of pixel ticks.
- Read path, 2-clk pipeline:
  - Stage 1 registers the address and raster flags.
  - Stage 2 registers the memory data.
  - Outputs reflect the raster position 2 clks after the counter update.
  - hsync, vsync, active and colour stay mutually aligned.
- Read/write collision: a same-address read and write in the same clk returns the old data (read-before-write).
- Raster flags:
  - active = hcount<H_ACTIVE && vcount<V_ACTIVE.
  - hsync low while hcount is in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN).
  - vsync low while vcount is in the equivalent V range.
- frame_start: asserts for exactly one clk, aligned with out_active for pixel (0,0).
- State machine IDLE/CLEAR:
  - IDLE + clear=1 -> CLEAR: clear_busy=1 next clk, sweep address=0.
  - CLEAR writes BG_COLOUR at one address per clk, 0..19199.
  - After address 19199 is written -> IDLE; clear_busy drops the following clk (busy for exactly 19200 clks).
  - clear asserted while in CLEAR is ignored (no restart).
  - plot during CLEAR is dropped.
  - Scanout continues during CLEAR and shows partially cleared contents.
- Reset mid-clear aborts the sweep immediately; the store is left partially cleared.
- Width rules:
  - hcount 8 bits, vcount 8 bits.
  - Address arithmetic 15 bits, no truncation for valid coordinates.
  - Divider is wide enough for CLK_DIV-1.

Decomposition:
- Shared package holds:
  - Screen constants H_ACTIVE/V_ACTIVE.
  - Colour codes: BG 3'b011, RUNNER 3'b100, PIPE 3'b110.
  - State enum IDLE/CLEAR.
  - Address width constant 15.
- One sub-module, frame_store_ram: simple dual-port, 19200x3, synchronous read, read-before-write.
- Raster counters and the clear FSM stay in frame_scanout.

Test Plan:
1. Reset and timing: reset, run with CLK_DIV=2 and no writes.
   - frame_start pulses every 200*130*2 = 52000 clks.
   - hsync low for 32 clks per line.
   - vsync low for 2 lines.
   - out_active high for 160 ticks per line on lines 0..119.
2. Write/readback:
   - plot (5,3)=3'b100 and (159,119)=3'b110.
   - The next frame shows 3'b100 at raster (5,3) and 3'b110 at (159,119), with output 2 clks after the counter update.
3. Out of range: plot x=160,y=0 and x=0,y=120 with colour 3'b111.
   - No location changes; address 0 and neighbours keep their prior values.
4. Clear:
   - Pulse clear; clear_busy is high for exactly 19200 clks.
   - A plot mid-sweep is dropped.
   - The following frame is all 3'b011 in the active window and 0 in blanking.
5. Reset mid-clear: assert resetn=0 at sweep address 5000.
   - clear_busy=0 immediately.
   - Addresses >=5000 retain their old contents.
6. Collision: write a new colour to the address being read in the same clk.
   - The current output shows the old colour.
   - The next frame shows the new colour.

Source files
------------

// File: rtl/frame_scanout_pkg.sv
// frame_scanout_pkg: shared screen geometry, colour codes, sweep state and pixel address helper
package frame_scanout_pkg;
  localparam int H_ACTIVE = 160;
  localparam int V_ACTIVE = 120;
  localparam int ADDR_W = 15;
  localparam int NPIX = H_ACTIVE * V_ACTIVE;
  localparam logic [2:0] COL_BG = 3'b011;
  localparam logic [2:0] COL_RUNNER = 3'b100;
  localparam logic [2:0] COL_PIPE = 3'b110;
  typedef enum logic {IDLE, CLEAR} state_t;
  // y*160 + x using shifts only
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
    return (ADDR_W'(py) << 7) + (ADDR_W'(py) << 5) + ADDR_W'(px);
  endfunction
endpackage

// File: rtl/frame_scanout_ram.sv
// frame_store_ram: 19200x3 simple dual-port store, synchronous read, read-before-write
module frame_store_ram import frame_scanout_pkg::*; (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [2:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [2:0]        rdata
);
  logic [2:0] mem [NPIX];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/frame_scanout.sv
// frame_scanout: captures plotted pixels into a frame store and scans it out as a raster video stream
module frame_scanout import frame_scanout_pkg::*; #(
  parameter int H_TOTAL = 200,
  parameter int V_TOTAL = 130,
  parameter int H_SYNC_START = 168,
  parameter int H_SYNC_LEN = 16,
  parameter int V_SYNC_START = 122,
  parameter int V_SYNC_LEN = 2,
  parameter int CLK_DIV = 2,
  parameter logic [2:0] BG_COLOUR = COL_BG
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  input  logic       clear,
  output logic       clear_busy,
  output logic [2:0] out_colour,
  output logic       out_active,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       frame_start
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0] h_q, h_d, v_q, v_d;
  logic tick, h_wrap, act, hs, vs, fs;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, clr_q, clr_d, waddr;
  logic act1_q, hs1_q, vs1_q, fs1_q, act2_q, hs2_q, vs2_q, fs2_q;
  state_t state_q, state_d;
  logic we;
  logic [2:0] wdata, rdata;
  always_comb begin
    tick = div_q == DIV_W'(CLK_DIV - 1);
    h_wrap = tick && h_q == 8'(H_TOTAL - 1);
    div_d = tick ? '0 : div_q + DIV_W'(1);
    h_d = h_wrap ? '0 : (tick ? h_q + 8'd1 : h_q);
    v_d = h_wrap ? (v_q == 8'(V_TOTAL - 1) ? '0 : v_q + 8'd1) : v_q;
    act = h_q < 8'(H_ACTIVE) && v_q < 8'(V_ACTIVE);
    hs = !(h_q >= 8'(H_SYNC_START) && h_q < 8'(H_SYNC_START + H_SYNC_LEN));
    vs = !(v_q >= 8'(V_SYNC_START) && v_q < 8'(V_SYNC_START + V_SYNC_LEN));
    // only the first clk of pixel (0,0) so the pulse is one clk wide for any divider
    fs = h_q == '0 && v_q == '0 && div_q == '0;
    rd_addr_d = act ? pix_addr(h_q, v_q[6:0]) : '0;
    state_d = state_q == IDLE ? (clear ? CLEAR : IDLE) : (clr_q == ADDR_W'(NPIX - 1) ? IDLE : CLEAR);
    clr_d = state_q == IDLE ? '0 : clr_q + ADDR_W'(1);
    we = state_q == CLEAR || (plot && x < 8'(H_ACTIVE) && y < 7'(V_ACTIVE));
    waddr = state_q == CLEAR ? clr_q : pix_addr(x, y);
    wdata = state_q == CLEAR ? BG_COLOUR : colour;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
      h_q <= '0;
      v_q <= '0;
      rd_addr_q <= '0;
      act1_q <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      fs1_q <= 1'b0;
      act2_q <= 1'b0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      fs2_q <= 1'b0;
      state_q <= IDLE;
      clr_q <= '0;
    end else begin
      div_q <= div_d;
      h_q <= h_d;
      v_q <= v_d;
      rd_addr_q <= rd_addr_d;
      act1_q <= act;
      hs1_q <= hs;
      vs1_q <= vs;
      fs1_q <= fs;
      act2_q <= act1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      fs2_q <= fs1_q;
      state_q <= state_d;
      clr_q <= clr_d;
    end
  end
  frame_store_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr_q),
    .rdata (rdata)
  );
  assign clear_busy = state_q == CLEAR;
  assign out_colour = act2_q ? rdata : 3'b000;
  assign out_active = act2_q;
  assign out_hsync = hs2_q;
  assign out_vsync = vs2_q;
  assign frame_start = fs2_q;
endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: table vectors, hand-written corner sequences and a per-clk reference model of the raster and store
module tb_frame_scanout;
  import frame_scanout_pkg::*;
  localparam int HT = 200, VT = 130, CD = 2;
  localparam int FRAME = HT * VT * CD;
  logic clk = 0, resetn = 0, plot = 0, clear = 0;
  logic [7:0] x = 0;
  logic [6:0] y = 0;
  logic [2:0] colour = 0;
  logic clear_busy, out_active, out_hsync, out_vsync, frame_start;
  logic [2:0] out_colour;
  frame_scanout dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot), .clear(clear),
    .clear_busy(clear_busy), .out_colour(out_colour), .out_active(out_active),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask
  // Reference model: raster position from elapsed clks, store as a plain array
  int cyc = 0, sweep = 0, mm = 0, mm_base = 0, m, pos, h, v, a;
  bit busy_m = 0, run_chk = 0, phase_c = 0;
  logic [2:0] mem_m [NPIX];
  bit known_m [NPIX];
  logic [2:0] e_col = 0;
  bit e_act = 0, e_hs = 1, e_vs = 1, e_fs = 0, e_busy = 0, e_known = 1;
  always @(posedge clk) begin
    if (!resetn) begin
      cyc = 0; busy_m = 0;
      e_act = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_col = 0; e_known = 1;
    end else begin
      cyc++;
      if (cyc >= 2) begin
        m = cyc - 2;
        pos = (m / CD) % (HT * VT);
        h = pos % HT;
        v = pos / HT;
        e_act = h < 160 && v < 120;
        e_hs = !(h >= 168 && h < 184);
        e_vs = !(v >= 122 && v < 124);
        e_fs = (m % CD == 0) && pos == 0;
        e_col = 0;
        e_known = 1;
        if (e_act) begin
          e_col = mem_m[v * 160 + h];
          e_known = known_m[v * 160 + h];
        end
      end
      if (busy_m) begin
        mem_m[sweep] = COL_BG;
        known_m[sweep] = 1;
        sweep++;
        busy_m = sweep < NPIX;
      end else begin
        if (plot && x < 160 && y < 120) begin
          a = int'(y) * 160 + int'(x);
          mem_m[a] = colour;
          known_m[a] = 1;
        end
        if (clear) begin busy_m = 1; sweep = 0; end
      end
    end
    e_busy = busy_m;
  end
  always @(negedge clk) if (run_chk && resetn) begin
    if (out_active !== e_act || out_hsync !== e_hs || out_vsync !== e_vs || frame_start !== e_fs ||
        clear_busy !== e_busy || (e_known && out_colour !== e_col)) begin
      mm++;
      if (mm - mm_base <= 5)
        $display("stream diff cyc %0d: act %b/%b hs %b/%b vs %b/%b fs %b/%b busy %b/%b col %0d/%0d", cyc,
                 out_active, e_act, out_hsync, e_hs, out_vsync, e_vs, frame_start, e_fs, clear_busy, e_busy, out_colour, e_col);
    end
  end
  int act_n = 0, hs_n = 0, vs_n = 0, hs_line = 0;
  int fs_q [$];
  always @(negedge clk) if (phase_c && resetn) begin
    if (frame_start) fs_q.push_back(cyc);
    if (cyc >= 2 && cyc <= FRAME + 1) begin
      act_n += int'(out_active);
      hs_n += int'(!out_hsync);
      vs_n += int'(!out_vsync);
      if (cyc <= HT * CD + 1) hs_line += int'(!out_hsync);
    end
  end
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  typedef struct {
    bit pe; int px; int py; logic [2:0] pc;
    int cx; int cy; int fr; logic [2:0] exp;
  } vec_t;
  vec_t tbl [9];
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, k, c;
    bit coll;
    tbl[0] = '{1, 160, 0, 3'b111, 0, 1, 0, COL_BG};
    tbl[1] = '{0, 0, 0, 3'b000, 4, 3, 0, COL_BG};
    tbl[2] = '{1, 5, 3, COL_RUNNER, 5, 3, 0, COL_RUNNER};
    tbl[3] = '{0, 0, 0, 3'b000, 0, 50, 0, COL_BG};
    tbl[4] = '{1, 159, 119, COL_PIPE, 159, 119, 0, COL_PIPE};
    tbl[5] = '{1, 0, 120, 3'b111, 0, 0, 1, COL_BG};
    tbl[6] = '{1, 255, 127, 3'b111, 1, 0, 1, COL_BG};
    tbl[7] = '{0, 0, 0, 3'b000, 20, 1, 1, 3'b101};
    tbl[8] = '{0, 0, 0, 3'b000, 5, 3, 1, COL_RUNNER};
    // Reset values and first pixel
    repeat (3) @(negedge clk);
    chk("rst_active", out_active, 0);
    chk("rst_hsync", out_hsync, 1);
    chk("rst_vsync", out_vsync, 1);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_colour", out_colour, 0);
    resetn = 1;
    run_chk = 1;
    wait_cyc(2);
    chk("first_fs", frame_start, 1);
    chk("first_active", out_active, 1);
    wait_cyc(3);
    chk("fs_one_clk", frame_start, 0);
    // Full clear with a dropped mid-sweep plot and an ignored re-clear
    clear = 1;
    @(negedge clk);
    clear = 0;
    n = 0;
    for (int i = 0; i < 30000 && clear_busy; i++) begin
      n++;
      if (n == 12000) begin x = 0; y = 50; colour = 3'b111; plot = 1; end
      if (n == 12001) plot = 0;
      clear = n == 15000;
      @(negedge clk);
    end
    chk("clear_len", n, NPIX);
    chk("stream_A", mm - mm_base, 0);
    mm_base = mm;
    // Random plots on both sides of the reset-abort point, then abort a sweep
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      c = $urandom_range(0, 6);
      if (c >= 3) c++;
      x = 8'($urandom_range(0, 159));
      y = 7'(i % 2 ? $urandom_range(60, 119) : $urandom_range(0, 30));
      colour = 3'(c);
      plot = 1;
    end
    @(negedge clk);
    plot = 0;
    clear = 1;
    @(negedge clk);
    clear = 0;
    n = 0;
    for (int i = 0; i < 30000 && clear_busy; i++) begin
      n++;
      if (n == 5001) break;
      @(negedge clk);
    end
    chk("sweep_reach", n, 5001);
    chk("busy_before_rst", clear_busy, 1);
    resetn = 0;
    #1;
    chk("midrst_busy", clear_busy, 0);
    chk("midrst_active", out_active, 0);
    chk("midrst_hsync", out_hsync, 1);
    repeat (3) @(negedge clk);
    chk("stream_B", mm - mm_base, 0);
    mm_base = mm;
    // Readback frame: table plots, collision, and full-frame timing
    resetn = 1;
    phase_c = 1;
    foreach (tbl[i]) if (tbl[i].pe) begin
      @(negedge clk);
      x = 8'(tbl[i].px);
      y = 7'(tbl[i].py);
      colour = tbl[i].pc;
      plot = 1;
    end
    @(negedge clk);
    plot = 0;
    coll = 0;
    foreach (tbl[i]) begin
      k = 2 + tbl[i].fr * FRAME + CD * (tbl[i].cy * HT + tbl[i].cx);
      if (!coll && k > 443) begin
        wait_cyc(442);
        x = 20; y = 1; colour = 3'b101; plot = 1;
        wait_cyc(443);
        plot = 0;
        chk("collision_old", out_colour, COL_BG);
        chk("collision_active", out_active, 1);
        coll = 1;
      end
      wait_cyc(k);
      chk($sformatf("vec%0d_colour", i), out_colour, tbl[i].exp);
    end
    chk("fs_pulses", fs_q.size(), 2);
    if (fs_q.size() == 2) begin
      chk("fs_first", fs_q[0], 2);
      chk("fs_period", fs_q[1] - fs_q[0], FRAME);
    end
    chk("active_clks", act_n, 160 * 120 * CD);
    chk("hsync_low_frame", hs_n, VT * 16 * CD);
    chk("hsync_low_line", hs_line, 16 * CD);
    chk("vsync_low_frame", vs_n, 2 * HT * CD);
    chk("stream_C", mm - mm_base, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
